// File: rtl/mfp_mac_pipe.sv
// mfp_mac_pipe: 3-stage saturating fixed-point MAC (multiply, accumulate, shift+saturate) over in_first/in_last packets.
// Define MFP_MAC_ROUND_EN to round half up before the output shift instead of truncating.
module mfp_mac_pipe #(
  parameter int In1W = 8,
  parameter int In2W = 8,
  parameter int AccW = 20,
  parameter int OutW = 8,
  parameter int FracShift = 7,
  parameter int isUnsigned = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_first,
  input  logic            in_last,
  input  logic [In1W-1:0] a,
  input  logic [In2W-1:0] b,
  output logic            out_valid,
  output logic [OutW-1:0] out_data,
  output logic            out_sat
);
  localparam int PW = In1W + In2W;
  localparam bit US = isUnsigned != 0;
  localparam logic [AccW-1:0] ACC_MAX = {US, {(AccW-1){1'b1}}};
  localparam logic [AccW-1:0] ACC_MIN = {!US, {(AccW-1){1'b0}}};
  localparam logic [OutW-1:0] OUT_MAX = {US, {(OutW-1){1'b1}}};
  localparam logic [OutW-1:0] OUT_MIN = {!US, {(OutW-1){1'b0}}};
  logic v1, f1, l1, fin2, acc_sat;
  logic [PW-1:0] p1, ax, bx;
  logic [AccW-1:0] acc;
  logic [AccW:0] pe, ae, sum, rx, r;
  logic signed [AccW:0] rs;
  logic s_hi, s_lo, o_hi, o_lo;
  // All arithmetic runs one bit wider than the accumulator so overflow is visible before clamping
  always_comb begin
    ax = {{In2W{US ? 1'b0 : a[In1W-1]}}, a};
    bx = {{In1W{US ? 1'b0 : b[In2W-1]}}, b};
    pe = {{(AccW+1-PW){US ? 1'b0 : p1[PW-1]}}, p1};
    ae = {US ? 1'b0 : acc[AccW-1], acc};
    sum = (f1 ? '0 : ae) + pe;
    s_hi = US ? sum[AccW] : !sum[AccW] && sum[AccW-1];
    s_lo = !US && sum[AccW] && !sum[AccW-1];
`ifdef MFP_MAC_ROUND_EN
    rx = ae + (AccW+1)'(2**FracShift/2);
`else
    rx = ae;
`endif
    rs = $signed(rx) >>> FracShift;
    r = US ? rx >> FracShift : rs;
    o_hi = US ? |r[AccW:OutW] : !r[AccW] && |r[AccW-1:OutW-1];
    o_lo = !US && r[AccW] && !(&r[AccW-1:OutW-1]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      f1 <= 1'b0;
      l1 <= 1'b0;
      p1 <= '0;
      fin2 <= 1'b0;
      acc <= '0;
      acc_sat <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        f1 <= in_first;
        l1 <= in_last;
        p1 <= ax * bx;
      end
      fin2 <= v1 && l1;
      if (v1) begin
        acc <= s_hi ? ACC_MAX : s_lo ? ACC_MIN : sum[AccW-1:0];
        acc_sat <= s_hi || s_lo || (!f1 && acc_sat);
      end
      out_valid <= fin2;
      if (fin2) begin
        out_data <= o_hi ? OUT_MAX : o_lo ? OUT_MIN : r[OutW-1:0];
        out_sat <= acc_sat || o_hi || o_lo;
      end
    end
  end
endmodule

// File: tb/tb_mfp_mac_pipe.sv
// tb_mfp_mac_pipe: directed checks on signed, unsigned and narrow-accumulator instances sharing one stimulus stream.
module tb_mfp_mac_pipe;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic ov0, ovu, ov16, os0, osu, os16;
  logic [7:0] od0, odu, od16;
  int cyc = 0, n_vec = 0, n_err = 0;
  typedef struct {logic [7:0] d; logic s; int c;} ev_t;
  ev_t q0[$], qu[$], q16[$];

  mfp_mac_pipe #(.isUnsigned(0)) d0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .a(a), .b(b), .out_valid(ov0), .out_data(od0), .out_sat(os0));
  mfp_mac_pipe #(.isUnsigned(1)) du (.clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .a(a), .b(b), .out_valid(ovu), .out_data(odu), .out_sat(osu));
  mfp_mac_pipe #(.AccW(16)) d16 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .a(a), .b(b), .out_valid(ov16), .out_data(od16), .out_sat(os16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ov0) q0.push_back('{od0, os0, cyc});
    if (ovu) qu.push_back('{odu, osu, cyc});
    if (ov16) q16.push_back('{od16, os16, cyc});
  end

  task automatic send(input logic f, input logic l, input logic [7:0] x, input logic [7:0] y);
    @(posedge clk); #1;
    in_valid = 1'b1; in_first = f; in_last = l; a = x; b = y;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    end
  endtask

  task automatic flush();
    q0.delete(); qu.delete(); q16.delete();
  endtask

  task automatic test_reset();
    idle(3);
    n_vec++; if ({ov0, od0, os0} !== 10'd0) begin n_err++; $display("FAIL reset_s got v=%b d=%0d s=%b want 0", ov0, od0, os0); end
    n_vec++; if ({ovu, odu, osu} !== 10'd0) begin n_err++; $display("FAIL reset_u got v=%b d=%0d s=%b want 0", ovu, odu, osu); end
    n_vec++; if ({ov16, od16, os16} !== 10'd0) begin n_err++; $display("FAIL reset_16 got v=%b d=%0d s=%b want 0", ov16, od16, os16); end
    rst = 1'b0;
  endtask

  task automatic test_single_signed();
    int t;
    flush();
    send(1, 1, 8'h80, 8'h80); t = cyc;
    idle(6);
    n_vec++; if (q0.size() != 1) begin n_err++; $display("FAIL single_cnt got %0d pulses want 1", q0.size()); end
    else begin
      n_vec++; if (q0[0].d !== 8'd127) begin n_err++; $display("FAIL single_data got %0d want 127", q0[0].d); end
      n_vec++; if (q0[0].s !== 1'b1) begin n_err++; $display("FAIL single_sat got %b want 1", q0[0].s); end
      n_vec++; if (q0[0].c - t !== 3) begin n_err++; $display("FAIL single_latency got %0d want 3", q0[0].c - t); end
    end
    n_vec++; if (od0 !== 8'd127 || ov0 !== 1'b0) begin n_err++; $display("FAIL single_hold got d=%0d v=%b want 127 0", od0, ov0); end
  endtask

  task automatic test_unsigned();
    flush();
    send(1, 1, 8'd255, 8'd255);
    idle(6);
    n_vec++; if (qu.size() != 1) begin n_err++; $display("FAIL uns_cnt got %0d want 1", qu.size()); end
    else begin
      n_vec++; if (qu[0].d !== 8'd255 || qu[0].s !== 1'b1) begin n_err++; $display("FAIL uns_result got d=%0d s=%b want 255 1", qu[0].d, qu[0].s); end
    end
  endtask

  task automatic test_gap_b2b();
    int t;
    logic [7:0] ed[2] = '{8'd8, 8'd0};
    flush();
    send(1, 0, 8'd16, 8'd16);
    send(0, 0, 8'd16, 8'd16);
    idle(2);
    send(0, 0, 8'd16, 8'd16);
    send(0, 1, 8'd16, 8'd16); t = cyc;
    send(1, 1, 8'd1, 8'd1);
    idle(6);
    n_vec++; if (q0.size() != 2) begin n_err++; $display("FAIL gap_cnt got %0d want 2", q0.size()); end
    for (int i = 0; i < q0.size() && i < 2; i++) begin
      n_vec++; if (q0[i].d !== ed[i] || q0[i].s !== 1'b0) begin n_err++; $display("FAIL gap_result[%0d] got d=%0d s=%b want %0d 0", i, q0[i].d, q0[i].s, ed[i]); end
    end
    if (q0.size() == 2) begin
      n_vec++; if (q0[0].c - t !== 3 || q0[1].c - q0[0].c !== 1) begin n_err++; $display("FAIL gap_timing got lat=%0d spacing=%0d want 3 1", q0[0].c - t, q0[1].c - q0[0].c); end
    end
  endtask

  task automatic test_acc_clamp();
    logic [7:0] ed[2] = '{8'd127, 8'd0};
    logic es[2] = '{1'b1, 1'b0};
    flush();
    send(1, 0, 8'd127, 8'd127);
    send(0, 0, 8'd127, 8'd127);
    send(0, 1, 8'd127, 8'd127);
    send(1, 1, 8'd2, 8'd3);
    idle(6);
    n_vec++; if (q16.size() != 2) begin n_err++; $display("FAIL clamp_cnt got %0d want 2", q16.size()); end
    for (int i = 0; i < q16.size() && i < 2; i++) begin
      n_vec++; if (q16[i].d !== ed[i] || q16[i].s !== es[i]) begin n_err++; $display("FAIL clamp_result[%0d] got d=%0d s=%b want %0d %b", i, q16[i].d, q16[i].s, ed[i], es[i]); end
    end
  endtask

  task automatic test_round();
`ifdef MFP_MAC_ROUND_EN
    logic [7:0] e = 8'h82;
`else
    logic [7:0] e = 8'h81;
`endif
    flush();
    send(1, 1, 8'h81, 8'd127);
    idle(6);
    n_vec++; if (q0.size() != 1) begin n_err++; $display("FAIL round_cnt got %0d want 1", q0.size()); end
    else begin
      n_vec++; if (q0[0].d !== e || q0[0].s !== 1'b0) begin n_err++; $display("FAIL round_result got d=%h s=%b want %h 0", q0[0].d, q0[0].s, e); end
    end
  endtask

  task automatic test_restart();
    flush();
    send(1, 0, 8'd100, 8'd100);
    send(1, 1, 8'd16, 8'd16);
    idle(6);
    n_vec++; if (q0.size() != 1) begin n_err++; $display("FAIL restart_cnt got %0d want 1", q0.size()); end
    else begin
      n_vec++; if (q0[0].d !== 8'd2 || q0[0].s !== 1'b0) begin n_err++; $display("FAIL restart_result got d=%0d s=%b want 2 0", q0[0].d, q0[0].s); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ed[2] = '{8'd2, 8'd1};
    flush();
    send(1, 0, 8'd50, 8'd50);
    send(0, 0, 8'd50, 8'd50);
    @(posedge clk); #1;
    rst = 1'b1; in_first = 1'b0; in_last = 1'b1;
    #1;
    n_vec++; if ({ov0, od0, os0} !== 10'd0) begin n_err++; $display("FAIL midrst_outputs got v=%b d=%0d s=%b want 0", ov0, od0, os0); end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    idle(5);
    n_vec++; if (q0.size() != 0 || od0 !== 8'd0) begin n_err++; $display("FAIL midrst_abort got %0d pulses d=%0d want 0 0", q0.size(), od0); end
    send(0, 1, 8'd64, 8'd4);
    send(1, 1, 8'd64, 8'd2);
    idle(6);
    n_vec++; if (q0.size() != 2) begin n_err++; $display("FAIL postrst_cnt got %0d want 2", q0.size()); end
    for (int i = 0; i < q0.size() && i < 2; i++) begin
      n_vec++; if (q0[i].d !== ed[i] || q0[i].s !== 1'b0) begin n_err++; $display("FAIL postrst_result[%0d] got d=%0d s=%b want %0d 0", i, q0[i].d, q0[i].s, ed[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_signed();
    test_unsigned();
    test_gap_b2b();
    test_acc_clamp();
    test_round();
    test_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
